exchange_order_issuer: RTL and testbench
========================================

Name: exchange_order_issuer

Overview:
- Front-end stage that feeds the exchange-side inputs of the upstream/downstream order processor: exchange_client_id, exchange_amount and exchange_go.
- Accepts exchange orders over a valid/ready stream and buffers them in a small FIFO.
- Replays each order as a pulse stretched to HOLD_CYCLES, followed by a GAP_CYCLES low gap.
- The stretching guarantees the processor, sampling on its slower clock, sees exactly one exchange_go per order.

Parameters:
- DEPTH, 8: FIFO entries; power of two, >= 2.
- HOLD_CYCLES, 4: clk cycles exchange_go stays high per order; >= 1. Must be >= the slowclk/clk period ratio.
- GAP_CYCLES, 4: clk cycles exchange_go stays low between orders; >= 1. Elaboration error if 0.
- CLIENT_W, 5: client id width.
- AMOUNT_W, 16: amount width.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: input order valid.
- in_ready, out, 1: block can accept an order.
- in_client_id, in, CLIENT_W: order client id.
- in_amount, in, AMOUNT_W: order amount.
- flush, in, 1: synchronous clear of queue and issue engine.
- exchange_client_id, out, CLIENT_W: issued client id.
- exchange_amount, out, AMOUNT_W: issued amount.
- exchange_go, out, 1: stretched issue strobe.
- fifo_count, out, $clog2(DEPTH+1): occupancy.
- drop_count, out, 16: zero-amount orders discarded; saturating.
- issued_count, out, 32: orders issued; see Optional Feature.

Behaviour:
- Reset (rst_n low, async): FIFO empty; FSM in IDLE; all outputs 0 except in_ready. in_ready is 1 one cycle after reset release.
- Handshake:
  - in_ready = !full && !flush. No combinational path from in_valid to in_ready.
  - An order is accepted on an edge where in_valid && in_ready.
- Zero filter: an accepted order with in_amount == 0 is not stored. drop_count increments by 1 and saturates at 0xFFFF.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE: if FIFO non-empty, pop the head into the output registers, set exchange_go = 1, load hold counter, go to DRIVE.
  - DRIVE: hold counter counts down. After HOLD_CYCLES cycles of go high: exchange_go = 0, load gap counter, go to GAP.
  - GAP: after GAP_CYCLES cycles, go to IDLE.
  - IDLE with an empty FIFO: stay in IDLE.
- Latency: an order accepted on edge t into an empty FIFO with the FSM in IDLE gives exchange_go = 1 after edge t+1 (2-cycle latency). exchange_client_id and exchange_amount change on that same edge.
- Output stability:
  - exchange_client_id and exchange_amount are stable throughout DRIVE and GAP.
  - In IDLE they retain the last issued values; exchange_go is 0.
- Rate: steady-state throughput is one order per HOLD_CYCLES + GAP_CYCLES + 1 cycles.
- Full FIFO: in_ready = 0, so no overwrite. A pop on an edge frees a slot and in_ready rises after that edge. There is no same-cycle push-while-full.
- Simultaneous push and pop with the FIFO not full: both occur; fifo_count is unchanged.
- Flush (priority over everything except reset):
  - Next edge: FIFO emptied, FSM to IDLE, exchange_go = 0, exchange_client_id and exchange_amount = 0.
  - drop_count and issued_count are kept.
  - An order presented during flush is not accepted, because in_ready = 0.
- Reset mid-DRIVE: exchange_go falls immediately (async). No partial pulse is replayed after reset.

Optional Feature:
- Macro: EXCHANGE_ISSUER_STATS_EN.
- Defined: issued_count increments on each IDLE->DRIVE transition and wraps at 2^32. Reset to 0; unaffected by flush.
- Undefined: issued_count is tied to 0 and no counter logic is synthesised. The port stays present so the port list is identical in both builds.

Decomposition:
- Package exchange_issuer_pkg:
  - issuer_state_e enum {IDLE, DRIVE, GAP}.
  - order_t packed struct {client_id[CLIENT_W-1:0], amount[AMOUNT_W-1:0]} with default widths 5 and 16.
  - DROP_CNT_MAX constant = 16'hFFFF.
- One sub-module: sync_fifo.
  - Parameterised by DEPTH and width.
  - Push/pop ports, full/empty/count outputs, async active-low reset, synchronous clear used by flush.
- The FSM, counters and filter live in exchange_order_issuer.

Test Plan:
1. Single order (id 3, amount 0x0100) into an idle block -> exchange_go high 2 cycles after acceptance for exactly 4 cycles, id=3, amount=0x0100 stable, then low for 4 cycles; fifo_count returns to 0.
2. Burst of 10 back-to-back orders with DEPTH=8 -> in_ready drops once 8 are buffered (the 9th is taken after the first pop). All 10 are issued in order, with go pulses exactly 9 cycles apart; no order lost or duplicated.
3. Orders with amounts 0, 5, 0 -> only amount 5 is issued; drop_count = 2. Preload drop_count near 0xFFFF via 65537 zero orders -> it stays at 0xFFFF.
4. Flush asserted mid-DRIVE with 3 orders queued -> next edge: go = 0, id/amount = 0, fifo_count = 0, FSM IDLE. An order presented with flush is not accepted; the next order after flush issues normally.
5. rst_n pulled low mid-DRIVE, asynchronously -> go = 0 immediately, all outputs 0. After release there is no residual pulse, and in_ready = 1 one cycle later.
6. With EXCHANGE_ISSUER_STATS_EN: 5 issued orders plus 1 zero order -> issued_count = 5, unchanged by flush. Without the macro: issued_count stays 0.

Source files
------------

// File: rtl/exchange_issuer_pkg.sv
// exchange_issuer_pkg: shared state encoding, order layout and limits for the exchange order issuer
package exchange_issuer_pkg;
   localparam int DEF_CLIENT_W = 5;
   localparam int DEF_AMOUNT_W = 16;
   localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;
   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2} issuer_state_e;
   typedef struct packed {
      logic [DEF_CLIENT_W-1:0] client_id;
      logic [DEF_AMOUNT_W-1:0] amount;
   } order_t;
endpackage

// File: rtl/exchange_order_issuer_sync_fifo.sv
// sync_fifo: power-of-two register FIFO with async reset and a synchronous clear
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int W = 21
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 wdata,
   output logic [W-1:0]                 rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo DEPTH must be a power of two >= 2");
   end
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;
   assign full    = cnt_q == CW'(DEPTH);
   assign empty   = cnt_q == '0;
   assign count   = cnt_q;
   assign rdata   = mem_q[rd_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (clr) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push && !clr) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/exchange_order_issuer.sv
// exchange_order_issuer: buffers orders and replays each as a HOLD_CYCLES-wide exchange_go pulse plus gap.
// Define EXCHANGE_ISSUER_STATS_EN to build the issued_count counter; otherwise it reads 0.
module exchange_order_issuer
   import exchange_issuer_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 4,
   parameter int CLIENT_W    = 5,
   parameter int AMOUNT_W    = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CLIENT_W-1:0]          in_client_id,
   input  logic [AMOUNT_W-1:0]          in_amount,
   input  logic                         flush,
   output logic [CLIENT_W-1:0]          exchange_client_id,
   output logic [AMOUNT_W-1:0]          exchange_amount,
   output logic                         exchange_go,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic [15:0]                  drop_count,
   output logic [31:0]                  issued_count
);
   localparam int W  = CLIENT_W + AMOUNT_W;
   localparam int CW = $clog2((HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES) + 1);
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_DRIVE = DRIVE;
   localparam logic [1:0] S_GAP   = GAP;
   if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_timing
      $error("HOLD_CYCLES and GAP_CYCLES must both be >= 1");
   end
   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                go_q, go_d;
   logic [CLIENT_W-1:0] id_q, id_d;
   logic [AMOUNT_W-1:0] amt_q, amt_d;
   logic [15:0]         drop_q, drop_d;
   logic                full, empty, accept, push, pop;
   logic [W-1:0]        head;
   assign in_ready = !full && !flush;
   assign accept   = in_valid && in_ready;
   assign push     = accept && (in_amount != '0);
   assign pop      = (state_q == S_IDLE) && !empty && !flush;
   sync_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk(clk), .rst_n(rst_n), .clr(flush), .push(push), .pop(pop),
      .wdata({in_client_id, in_amount}), .rdata(head),
      .full(full), .empty(empty), .count(fifo_count)
   );
   // The counter holds cycles remaining minus one, so a zero count ends the phase on the next edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      go_d    = go_q;
      id_d    = id_q;
      amt_d   = amt_q;
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         go_d    = 1'b0;
         id_d    = '0;
         amt_d   = '0;
      end else if (state_q == S_IDLE) begin
         if (pop) begin
            state_d       = S_DRIVE;
            cnt_d         = CW'(HOLD_CYCLES - 1);
            go_d          = 1'b1;
            {id_d, amt_d} = head;
         end
      end else if (state_q == S_DRIVE) begin
         if (cnt_q == '0) begin
            state_d = S_GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
            go_d    = 1'b0;
         end else cnt_d = cnt_q - 1'b1;
      end else begin
         if (cnt_q == '0) state_d = S_IDLE;
         else cnt_d = cnt_q - 1'b1;
      end
   end
   assign drop_d = (accept && in_amount == '0 && drop_q != DROP_CNT_MAX) ? drop_q + 16'd1 : drop_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         go_q    <= 1'b0;
         id_q    <= '0;
         amt_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         go_q    <= go_d;
         id_q    <= id_d;
         amt_q   <= amt_d;
         drop_q  <= drop_d;
      end
   assign exchange_go        = go_q;
   assign exchange_client_id = id_q;
   assign exchange_amount    = amt_q;
   assign drop_count         = drop_q;
`ifdef EXCHANGE_ISSUER_STATS_EN
   logic [31:0] issued_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) issued_q <= '0;
      else if (pop) issued_q <= issued_q + 32'd1;
   assign issued_count = issued_q;
`else
   assign issued_count = '0;
`endif
endmodule

// File: tb/tb_exchange_order_issuer.sv
// tb_exchange_order_issuer: directed checks of the exchange order issuer with default parameters
module tb_exchange_order_issuer;
`ifdef EXCHANGE_ISSUER_STATS_EN
   localparam logic [31:0] EXP_ISSUED = 32'd5;
`else
   localparam logic [31:0] EXP_ISSUED = 32'd0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_client_id = '0;
   logic [15:0] in_amount = '0;
   logic        flush = 1'b0;
   logic [4:0]  exchange_client_id;
   logic [15:0] exchange_amount;
   logic        exchange_go;
   logic [3:0]  fifo_count;
   logic [15:0] drop_count;
   logic [31:0] issued_count;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic go_prev = 1'b0;
   int rise_cyc[$];
   logic [4:0] rise_id[$];
   logic [15:0] rise_amt[$];

   exchange_order_issuer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_client_id(in_client_id), .in_amount(in_amount), .flush(flush),
      .exchange_client_id(exchange_client_id), .exchange_amount(exchange_amount),
      .exchange_go(exchange_go), .fifo_count(fifo_count), .drop_count(drop_count),
      .issued_count(issued_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (exchange_go && !go_prev) begin
         rise_cyc.push_back(cyc);
         rise_id.push_back(exchange_client_id);
         rise_amt.push_back(exchange_amount);
      end
      go_prev = exchange_go;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_rises;
      rise_cyc.delete();
      rise_id.delete();
      rise_amt.delete();
   endtask

   initial begin
      int k;
      logic acc, saw_full;
      // reset
      tick;
      chk("rst_go", exchange_go, 0);
      chk("rst_id", exchange_client_id, 0);
      chk("rst_amt", exchange_amount, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_issued", issued_count, 0);
      tick;
      rst_n = 1'b1;
      tick;
      chk("rst_ready", in_ready, 1);
      // single order
      in_valid = 1'b1; in_client_id = 5'd3; in_amount = 16'h0100;
      tick;
      in_valid = 1'b0;
      chk("single_count_after_accept", fifo_count, 1);
      chk("single_go_latency", exchange_go, 0);
      tick;
      chk("single_count_after_pop", fifo_count, 0);
      for (int i = 0; i < 4; i++) begin
         chk("single_go_high", exchange_go, 1);
         chk("single_id", exchange_client_id, 3);
         chk("single_amt", exchange_amount, 16'h0100);
         tick;
      end
      for (int i = 0; i < 4; i++) begin
         chk("single_go_low", exchange_go, 0);
         chk("single_id_hold", exchange_client_id, 3);
         tick;
      end
      tick;
      // burst of 10
      clear_rises();
      k = 0; saw_full = 1'b0;
      for (int n = 0; n < 60 && k < 10; n++) begin
         in_valid = 1'b1; in_client_id = 5'(10 + k); in_amount = 16'(16'h0200 + k);
         if (!in_ready && !saw_full) begin
            saw_full = 1'b1;
            chk("burst_full_count", fifo_count, 8);
            chk("burst_full_accepted", k, 9);
         end
         acc = in_ready;
         tick;
         if (acc) k++;
      end
      in_valid = 1'b0;
      chk("burst_all_accepted", k, 10);
      chk("burst_saw_full", saw_full, 1);
      for (int n = 0; n < 150 && rise_cyc.size() < 10; n++) tick;
      chk("burst_rises", rise_cyc.size(), 10);
      for (int i = 0; i < rise_cyc.size(); i++) begin
         chk("burst_order_id", rise_id[i], 10 + i);
         chk("burst_order_amt", rise_amt[i], 16'h0200 + i);
         if (i > 0) chk("burst_spacing", rise_cyc[i] - rise_cyc[i-1], 9);
      end
      for (int n = 0; n < 12; n++) tick;
      chk("burst_rises_final", rise_cyc.size(), 10);
      chk("burst_drained", fifo_count, 0);
      // zero filter
      clear_rises();
      in_valid = 1'b1; in_client_id = 5'd1; in_amount = 16'd0;
      tick;
      in_client_id = 5'd2; in_amount = 16'd5;
      tick;
      in_client_id = 5'd4; in_amount = 16'd0;
      tick;
      in_valid = 1'b0;
      for (int n = 0; n < 14; n++) tick;
      chk("zero_drop", drop_count, 2);
      chk("zero_rises", rise_cyc.size(), 1);
      if (rise_cyc.size() > 0) begin
         chk("zero_id", rise_id[0], 2);
         chk("zero_amt", rise_amt[0], 5);
      end
      in_valid = 1'b1; in_amount = 16'd0;
      for (int n = 0; n < 65531; n++) tick;
      chk("zero_drop_near_max", drop_count, 16'hFFFD);
      for (int n = 0; n < 6; n++) tick;
      chk("zero_drop_saturated", drop_count, 16'hFFFF);
      in_valid = 1'b0;
      chk("zero_none_stored", fifo_count, 0);
      chk("zero_no_issue", rise_cyc.size(), 1);
      // flush mid-DRIVE
      for (int j = 0; j < 4; j++) begin
         in_valid = 1'b1; in_client_id = 5'(20 + j); in_amount = 16'(16'h0040 + j);
         tick;
      end
      in_valid = 1'b0;
      chk("flush_pre_go", exchange_go, 1);
      chk("flush_pre_id", exchange_client_id, 20);
      chk("flush_pre_count", fifo_count, 3);
      flush = 1'b1; in_valid = 1'b1; in_client_id = 5'd25; in_amount = 16'd7;
      #1;
      chk("flush_ready_low", in_ready, 0);
      tick;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_go", exchange_go, 0);
      chk("flush_id", exchange_client_id, 0);
      chk("flush_amt", exchange_amount, 0);
      chk("flush_count", fifo_count, 0);
      chk("flush_drop_kept", drop_count, 16'hFFFF);
      tick;
      chk("flush_idle_go", exchange_go, 0);
      chk("flush_idle_count", fifo_count, 0);
      in_valid = 1'b1; in_client_id = 5'd26; in_amount = 16'h0033;
      tick;
      in_valid = 1'b0;
      chk("post_flush_count", fifo_count, 1);
      chk("post_flush_go_latency", exchange_go, 0);
      tick;
      chk("post_flush_go", exchange_go, 1);
      chk("post_flush_id", exchange_client_id, 26);
      chk("post_flush_amt", exchange_amount, 16'h0033);
      for (int n = 0; n < 12; n++) tick;
      // async reset mid-DRIVE
      in_valid = 1'b1; in_client_id = 5'd7; in_amount = 16'h0077;
      tick;
      in_client_id = 5'd8; in_amount = 16'h0088;
      tick;
      in_valid = 1'b0;
      chk("arst_pre_go", exchange_go, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_go", exchange_go, 0);
      chk("arst_id", exchange_client_id, 0);
      chk("arst_amt", exchange_amount, 0);
      chk("arst_count", fifo_count, 0);
      chk("arst_drop", drop_count, 0);
      tick;
      tick;
      rst_n = 1'b1;
      clear_rises();
      tick;
      chk("arst_ready", in_ready, 1);
      for (int n = 0; n < 15; n++) tick;
      chk("arst_no_residual", rise_cyc.size(), 0);
      chk("arst_go_low", exchange_go, 0);
      // issued counter
      chk("stats_reset", issued_count, 0);
      for (int j = 1; j <= 6; j++) begin
         in_valid = 1'b1; in_client_id = 5'(j); in_amount = (j == 6) ? 16'd0 : 16'(16'h0010 * j);
         tick;
      end
      in_valid = 1'b0;
      for (int n = 0; n < 80 && rise_cyc.size() < 5; n++) tick;
      for (int n = 0; n < 12; n++) tick;
      chk("stats_rises", rise_cyc.size(), 5);
      chk("stats_drop", drop_count, 1);
      chk("stats_issued", issued_count, EXP_ISSUED);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("stats_issued_after_flush", issued_count, EXP_ISSUED);
      chk("stats_drop_after_flush", drop_count, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
